// File: rtl/pixel_readout_seq_if.sv
// Pixel output stream of pixel_readout_seq: a valid/ready handshake carrying
// the pixel code and its (row, column) position in the frame.
interface pixel_readout_seq_if #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_last;

  modport master (output out_valid, out_data, out_row, out_col, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col, out_last, output out_ready);
endinterface

// File: rtl/pixel_readout_seq.sv
// Frame sequencer (erase/expose/convert/read) with row-buffered pixel streaming.
// Optional macro PIXRO_FRAME_TAG_EN adds frame_id and out_first outputs.
module pixel_readout_seq #(
  parameter int H_PIXELS     = 4,
  parameter int V_PIXELS     = 4,
  parameter int ADC_BITS     = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int EXPOSE_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         continuous,
  input  logic [EXPOSE_W-1:0]          expose_len,
  output logic                         erase,
  output logic                         expose,
  output logic                         convert,
  output logic [V_PIXELS-1:0]          read,
  output logic                         count_drv_en,
  output logic [ADC_BITS-1:0]          count_data,
  input  logic [H_PIXELS*ADC_BITS-1:0] col_data,
  pixel_readout_seq_if.master          stream,
`ifdef PIXRO_FRAME_TAG_EN
  output logic [7:0]                   frame_id,
  output logic                         out_first,
`endif
  output logic                         busy
);
  localparam int ROW_W     = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam int COL_W     = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int CONV_LAST = (1 << ADC_BITS) - 1;
  localparam int CONV_W    = ADC_BITS + 1;
  localparam int ERA_W     = $clog2(ERASE_CYCLES + 1);
  localparam int MAX_A     = (EXPOSE_W > CONV_W) ? EXPOSE_W : CONV_W;
  localparam int CNT_W     = (MAX_A > ERA_W) ? MAX_A : ERA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_RD_SETTLE, S_RD_CAPTURE, S_STREAM
  } state_t;

  state_t              state_r, state_nx;
  logic [CNT_W-1:0]    cnt_r, cnt_nx;
  logic [EXPOSE_W-1:0] exp_last_r, exp_last_nx;
  logic [ROW_W-1:0]    row_r, row_nx;
  logic [COL_W-1:0]    col_r, col_nx;
  logic [ADC_BITS-1:0] buf_r [H_PIXELS];
  logic [ADC_BITS-1:0] col_arr_s [H_PIXELS];

  logic                erase_r, expose_r, convert_r, busy_r;
  logic [V_PIXELS-1:0] read_r, read_nx;
  logic [ADC_BITS-1:0] count_r, count_nx;
  logic                valid_r, last_r;
  logic [ADC_BITS-1:0] data_r, data_nx;
  logic [ROW_W-1:0]    orow_r;
  logic [COL_W-1:0]    ocol_r;
  logic                xfer_s;

  for (genvar c = 0; c < H_PIXELS; c++) begin : g_cols
    assign col_arr_s[c] = col_data[c*ADC_BITS +: ADC_BITS];
  end

  assign xfer_s = valid_r && stream.out_ready;

  // Next-state and counter/position update for the frame sequencer.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    exp_last_nx = exp_last_r;
    row_nx      = row_r;
    col_nx      = col_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx    = S_ERASE;
          cnt_nx      = '0;
          exp_last_nx = (expose_len == '0) ? '0 : expose_len - EXPOSE_W'(1);
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ERASE: begin
        if (cnt_r == CNT_W'(ERASE_CYCLES - 1)) begin
          state_nx = S_EXPOSE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      S_EXPOSE: begin
        if (cnt_r == CNT_W'(exp_last_r)) begin
          state_nx = S_CONVERT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      S_CONVERT: begin
        if (cnt_r == CNT_W'(CONV_LAST)) begin
          state_nx = S_RD_SETTLE;
          cnt_nx   = '0;
          row_nx   = '0;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      S_RD_SETTLE:  state_nx = S_RD_CAPTURE;
      S_RD_CAPTURE: begin
        state_nx = S_STREAM;
        col_nx   = '0;
      end
      S_STREAM: begin
        if (xfer_s) begin
          if (col_r != COL_W'(H_PIXELS - 1)) begin
            col_nx = col_r + COL_W'(1);
          end else if (row_r != ROW_W'(V_PIXELS - 1)) begin
            row_nx   = row_r + ROW_W'(1);
            state_nx = S_RD_SETTLE;
          end else begin
            state_nx = continuous ? S_ERASE : S_IDLE;
            cnt_nx   = '0;
          end
        end else begin
          state_nx = S_STREAM;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output values for the coming cycle; the first beat of a row bypasses the buffer.
  always_comb begin
    read_nx  = '0;
    count_nx = '0;
    data_nx  = '0;
    for (int i = 0; i < V_PIXELS; i++) begin
      read_nx[i] = ((state_nx == S_RD_SETTLE) || (state_nx == S_RD_CAPTURE)) &&
                   (row_nx == ROW_W'(i));
    end
    if (state_nx == S_CONVERT) begin
      count_nx = cnt_nx[ADC_BITS-1:0];
    end else begin
      count_nx = '0;
    end
    if (state_nx != S_STREAM) begin
      data_nx = '0;
    end else if (state_r == S_RD_CAPTURE) begin
      data_nx = col_arr_s[col_nx];
    end else begin
      data_nx = buf_r[col_nx];
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      exp_last_r <= '0;
      row_r      <= '0;
      col_r      <= '0;
      erase_r    <= 1'b0;
      expose_r   <= 1'b0;
      convert_r  <= 1'b0;
      busy_r     <= 1'b0;
      read_r     <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      data_r     <= '0;
      orow_r     <= '0;
      ocol_r     <= '0;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      exp_last_r <= exp_last_nx;
      row_r      <= row_nx;
      col_r      <= col_nx;
      erase_r    <= (state_nx == S_ERASE);
      expose_r   <= (state_nx == S_EXPOSE);
      convert_r  <= (state_nx == S_CONVERT);
      busy_r     <= (state_nx != S_IDLE);
      read_r     <= read_nx;
      count_r    <= count_nx;
      valid_r    <= (state_nx == S_STREAM);
      last_r     <= (state_nx == S_STREAM) && (row_nx == ROW_W'(V_PIXELS - 1)) &&
                    (col_nx == COL_W'(H_PIXELS - 1));
      data_r     <= data_nx;
      orow_r     <= (state_nx == S_STREAM) ? row_nx : '0;
      ocol_r     <= (state_nx == S_STREAM) ? col_nx : '0;
    end
  end

  // Row buffer: holds one row of column codes; contents need no reset.
  always_ff @(posedge clk) begin
    if (state_r == S_RD_CAPTURE) begin
      buf_r <= col_arr_s;
    end
  end

`ifdef PIXRO_FRAME_TAG_EN
  logic [7:0] frame_id_r;
  logic       first_r;

  // Frame counter advances on the final transfer of each frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_id_r <= 8'd0;
      first_r    <= 1'b0;
    end else begin
      if ((state_r == S_STREAM) && xfer_s && last_r) begin
        frame_id_r <= frame_id_r + 8'd1;
      end
      first_r <= (state_nx == S_STREAM) && (row_nx == '0) && (col_nx == '0);
    end
  end

  assign frame_id  = frame_id_r;
  assign out_first = first_r;
`endif

  assign erase            = erase_r;
  assign expose           = expose_r;
  assign convert          = convert_r;
  assign read             = read_r;
  assign count_drv_en     = ~|read_r;
  assign count_data       = count_r;
  assign busy             = busy_r;
  assign stream.out_valid = valid_r;
  assign stream.out_data  = data_r;
  assign stream.out_row   = orow_r;
  assign stream.out_col   = ocol_r;
  assign stream.out_last  = last_r;
endmodule
